ud_button_pulser: RTL and testbench

//  Converts two raw, bouncing pushbuttons (up/down) into clean one-cycle incr/decr

---
 rtl/ud_button_pulser.sv | 147 ++++++++++++++
 tb/tb_ud_button_pulser.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ud_button_pulser.sv
// Two bouncing pushbuttons in, one-cycle incr/decr pulses out (mutually exclusive).
// Optional hold-to-repeat pulses are built only when AUTO_REPEAT_EN is defined.
module ud_button_pulser #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_RATE     = 16
) (
    input  logic clk,
    input  logic clr_n,
    input  logic btn_up,
    input  logic btn_dn,
    output logic incr,
    output logic decr
);
    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD_UP, HOLD_DN, LOCKOUT} state_t;

    // Per-button vectors: index 0 is the up button, index 1 the down button.
    logic [1:0]                  btn_raw;
    logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0][DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic [1:0]                  db_lvl_q, db_lvl_d;
    state_t                      state_q, state_d;
    logic                        incr_q, incr_d;
    logic                        decr_q, decr_d;
    logic                        u, d;
    logic                        rpt_fire;

    assign btn_raw = {btn_dn, btn_up};
    assign u       = db_lvl_q[0];
    assign d       = db_lvl_q[1];

    // NOTE: every *_d gets a default before any branch, so no path leaves it unassigned (no latch).
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            sync_d[b]   = {sync_q[b][SYNC_STAGES-2:0], btn_raw[b]};
            db_lvl_d[b] = db_lvl_q[b];
            db_cnt_d[b] = '0;
            if (sync_q[b][SYNC_STAGES-1] != db_lvl_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    db_lvl_d[b] = ~db_lvl_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int               RPT_MAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int               RPT_W      = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_rate_q, rpt_rate_d;

    // Counts from the last pulse; the first gap is REPEAT_DELAY, later gaps REPEAT_RATE.
    always_comb begin
        rpt_cnt_d  = '0;
        rpt_rate_d = 1'b0;
        rpt_fire   = 1'b0;
        if ((state_q == HOLD_UP && u && !d) || (state_q == HOLD_DN && d && !u)) begin
            rpt_rate_d = rpt_rate_q;
            if (rpt_cnt_q == (rpt_rate_q ? RATE_LAST : DELAY_LAST)) begin
                rpt_fire   = 1'b1;
                rpt_rate_d = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rpt_cnt_q  <= '0;
            rpt_rate_q <= 1'b0;
        end else begin
            rpt_cnt_q  <= rpt_cnt_d;
            rpt_rate_q <= rpt_rate_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        incr_d  = 1'b0;
        decr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (u && d) begin
                    state_d = LOCKOUT;
                end else if (u) begin
                    state_d = HOLD_UP;
                    incr_d  = 1'b1;
                end else if (d) begin
                    state_d = HOLD_DN;
                    decr_d  = 1'b1;
                end
            end
            HOLD_UP: begin
                if (!u)     state_d = IDLE;
                else if (d) state_d = LOCKOUT;
                else        incr_d  = rpt_fire;
            end
            HOLD_DN: begin
                if (!d)     state_d = IDLE;
                else if (u) state_d = LOCKOUT;
                else        decr_d  = rpt_fire;
            end
            LOCKOUT: begin
                if (!u && !d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every flop here, synchroniser included, is cleared by the async reset so a
    // mid-hold reset aborts immediately and a still-held button re-debounces from scratch.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_q   <= '0;
            db_cnt_q <= '0;
            db_lvl_q <= '0;
            state_q  <= IDLE;
            incr_q   <= 1'b0;
            decr_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so all flops sample the same pre-edge values.
            sync_q   <= sync_d;
            db_cnt_q <= db_cnt_d;
            db_lvl_q <= db_lvl_d;
            state_q  <= state_d;
            incr_q   <= incr_d;
            decr_q   <= decr_d;
        end
    end

    assign incr = incr_q;
    assign decr = decr_q;

endmodule

// File: tb/tb_ud_button_pulser.sv
// Self-checking bench for ud_button_pulser: reset table, directed multi-cycle cases,
// then randomized button activity compared against a cycle-level behavioural model.
module tb_ud_button_pulser;
    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int REPEAT_DELAY    = 20;
    localparam int REPEAT_RATE     = 8;
    localparam int LAT             = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
    localparam int HIST            = 64;
`ifdef AUTO_REPEAT_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif

    logic clk, clr_n, btn_up, btn_dn, incr, decr;
    int   n_cmp, n_bad;

    ud_button_pulser #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .btn_up(btn_up),
        .btn_dn(btn_dn),
        .incr  (incr),
        .decr  (decr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Raw samples are kept per edge; a level flips once the synchronised value has
    // disagreed with it on each of the last DEBOUNCE_CYCLES edges.
    typedef enum int {M_NONE, M_UP, M_DN, M_LOCK} owner_t;
    bit     m_raw [2][HIST];
    bit     m_lvl [2];
    int     m_edge, m_age;
    owner_t m_owner;
    bit     m_exp_incr, m_exp_decr;

    function automatic bit m_synced(input int b, input int e);
        if (e - SYNC_STAGES < 1) return 1'b0;
        return m_raw[b][(e - SYNC_STAGES) % HIST];
    endfunction

    function automatic bit m_repeat_due(input int age);
        return REPEAT && age >= REPEAT_DELAY && ((age - REPEAT_DELAY) % REPEAT_RATE) == 0;
    endfunction

    task automatic model_reset();
        m_edge = 0; m_age = 0; m_owner = M_NONE;
        m_lvl[0] = 1'b0; m_lvl[1] = 1'b0;
        m_exp_incr = 1'b0; m_exp_decr = 1'b0;
    endtask

    task automatic model_step();
        bit u, d, flip;
        m_edge++;
        m_raw[0][m_edge % HIST] = btn_up;
        m_raw[1][m_edge % HIST] = btn_dn;
        u = m_lvl[0];
        d = m_lvl[1];
        m_exp_incr = 1'b0;
        m_exp_decr = 1'b0;
        case (m_owner)
            M_NONE: begin
                if (u && d)  m_owner = M_LOCK;
                else if (u) begin m_owner = M_UP; m_age = 0; m_exp_incr = 1'b1; end
                else if (d) begin m_owner = M_DN; m_age = 0; m_exp_decr = 1'b1; end
            end
            M_UP: begin
                if (!u)     m_owner = M_NONE;
                else if (d) m_owner = M_LOCK;
                else begin m_age++; m_exp_incr = m_repeat_due(m_age); end
            end
            M_DN: begin
                if (!d)     m_owner = M_NONE;
                else if (u) m_owner = M_LOCK;
                else begin m_age++; m_exp_decr = m_repeat_due(m_age); end
            end
            default: if (!u && !d) m_owner = M_NONE;
        endcase
        for (int b = 0; b < 2; b++) begin
            flip = 1'b1;
            for (int j = 0; j < DEBOUNCE_CYCLES; j++)
                if (m_synced(b, m_edge - j) == m_lvl[b]) flip = 1'b0;
            if (flip) m_lvl[b] = !m_lvl[b];
        end
    endtask

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) model_reset();
        else        model_step();
    end

    // ---------------- helpers ----------------
    task automatic count_pulses(input int n, output int ni, output int nd);
        ni = 0; nd = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ni += int'(incr);
            nd += int'(decr);
        end
    endtask

    task automatic wait_pulse(input bit want_dn, input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget && lat < 0; k++) begin
            @(negedge clk);
            if (want_dn ? decr : incr) lat = k;
        end
    endtask

    typedef struct {
        logic clr_n;
        logic up;
        logic dn;
        logic exp_incr;
        logic exp_decr;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ni, nd, lat, n_off;
        int offs [64];

        // Three cycles in reset with up held, then release: one incr LAT edges later.
        for (int i = 0; i < 15; i++)
            vecs[i] = '{clr_n: logic'(i >= 3), up: 1'b1, dn: 1'b0, exp_incr: 1'b0, exp_decr: 1'b0};
        vecs[3 + LAT - 1].exp_incr = 1'b1;

        n_cmp = 0; n_bad = 0;
        clr_n = 1'b0; btn_up = 1'b0; btn_dn = 1'b0;
        @(negedge clk);

        // 1: reset with button held, then first press
        for (int i = 0; i < 15; i++) begin
            clr_n  = vecs[i].clr_n;
            btn_up = vecs[i].up;
            btn_dn = vecs[i].dn;
            @(negedge clk);
            check($sformatf("tbl%0d_incr", i), int'(incr), int'(vecs[i].exp_incr));
            check($sformatf("tbl%0d_decr", i), int'(decr), int'(vecs[i].exp_decr));
        end

        // release is silent
        btn_up = 1'b0;
        count_pulses(16, ni, nd);
        check("s1_release_incr", ni, 0);
        check("s1_release_decr", nd, 0);

        // 2: bounce every 2 cycles never reaches the debounce threshold
        ni = 0; nd = 0;
        for (int i = 0; i < 24; i++) begin
            btn_up = ((i / 2) % 2) == 0;
            @(negedge clk);
            ni += int'(incr);
            nd += int'(decr);
        end
        btn_up = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ni += int'(incr);
            nd += int'(decr);
        end
        check("s2_bounce_incr", ni, 0);
        check("s2_bounce_decr", nd, 0);

        // 3: simultaneous press locks out, later single press works
        btn_up = 1'b1; btn_dn = 1'b1;
        count_pulses(40, ni, nd);
        check("s3_both_incr", ni, 0);
        check("s3_both_decr", nd, 0);
        btn_up = 1'b0; btn_dn = 1'b0;
        count_pulses(12, ni, nd);
        check("s3_release_pulses", ni + nd, 0);
        btn_dn = 1'b1;
        wait_pulse(1'b1, 30, lat);
        check("s3_dn_latency", lat, LAT);
        count_pulses(10, ni, nd);
        check("s3_dn_single", nd, 0);
        check("s3_dn_no_incr", ni, 0);

        // 4: down pressed while up held, then up released with down still held
        btn_dn = 1'b0;
        count_pulses(12, ni, nd);
        btn_up = 1'b1;
        wait_pulse(1'b0, 30, lat);
        check("s4_up_latency", lat, LAT);
        btn_dn = 1'b1;
        count_pulses(30, ni, nd);
        check("s4_overlap_decr", nd, 0);
        check("s4_overlap_incr", ni, 0);
        btn_up = 1'b0;
        count_pulses(30, ni, nd);
        check("s4_dn_only_decr", nd, 0);
        check("s4_dn_only_incr", ni, 0);
        btn_dn = 1'b0;
        count_pulses(12, ni, nd);
        btn_dn = 1'b1;
        wait_pulse(1'b1, 30, lat);
        check("s4_repress_latency", lat, LAT);

        // 5: long hold, auto-repeat schedule
        btn_dn = 1'b0;
        count_pulses(12, ni, nd);
        btn_up = 1'b1;
        wait_pulse(1'b0, 30, lat);
        check("s5_first_latency", lat, LAT);
        n_off = 0; nd = 0;
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            nd += int'(decr);
            if (incr && n_off < 64) begin
                offs[n_off] = t;
                n_off++;
            end
        end
        check("s5_repeat_count", n_off, REPEAT ? ((60 - REPEAT_DELAY) / REPEAT_RATE + 1) : 0);
        check("s5_no_decr", nd, 0);
        for (int i = 0; i < n_off && i < 8; i++)
            check($sformatf("s5_repeat%0d_offset", i), offs[i], REPEAT_DELAY + i * REPEAT_RATE);

        // 6: asynchronous reset during down auto-repeat
        btn_up = 1'b0;
        count_pulses(12, ni, nd);
        btn_dn = 1'b1;
        wait_pulse(1'b1, 30, lat);
        check("s6_first_latency", lat, LAT);
        wait_pulse(1'b1, 25, lat);
        check("s6_repeat1_gap", lat, REPEAT ? REPEAT_DELAY : -1);
        wait_pulse(1'b1, 12, lat);
        check("s6_repeat2_gap", lat, REPEAT ? REPEAT_RATE : -1);
        check("s6_decr_before_reset", int'(decr), REPEAT ? 1 : 0);
        clr_n = 1'b0;
        #1;
        check("s6_decr_async_clear", int'(decr), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("s6_in_reset%0d", i), int'(decr) + int'(incr), 0);
        end
        clr_n = 1'b1;
        wait_pulse(1'b1, 30, lat);
        check("s6_post_reset_latency", lat, LAT);
        wait_pulse(1'b1, 25, lat);
        check("s6_post_reset_repeat", lat, REPEAT ? REPEAT_DELAY : -1);
        btn_dn = 1'b0;
        count_pulses(12, ni, nd);

        // Randomized segments against the reference model
        for (int s = 0; s < 90; s++) begin
            int kind, len;
            bit noisy, up_lvl, dn_lvl;
            kind   = int'($urandom_range(0, 9));
            len    = int'($urandom_range(1, 45));
            noisy  = ($urandom_range(0, 3) == 0);
            up_lvl = (kind inside {1, 2, 3, 7});
            dn_lvl = (kind inside {4, 5, 6, 7});
            if (kind == 0) begin
                clr_n = 1'b0;
                len   = int'($urandom_range(1, 3));
            end
            for (int c = 0; c < len; c++) begin
                btn_up = up_lvl ^ (noisy && ($urandom_range(0, 2) == 0));
                btn_dn = dn_lvl ^ (noisy && ($urandom_range(0, 2) == 0));
                @(negedge clk);
                check("rand_incr", int'(incr), int'(m_exp_incr));
                check("rand_decr", int'(decr), int'(m_exp_decr));
            end
            clr_n = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
